// File: rtl/quadrature_debounce_if.sv
// Signal bundle between an encoder pin pair, its conditioner and the decoder.
// The slave side is the conditioner; the master side drives pins and consumes results.
interface quadrature_debounce_if;
   logic       a_raw;
   logic       b_raw;
   logic       err_clr;
   logic       a_out;
   logic       b_out;
   logic       chg;
   logic       err;
   logic [7:0] glitch_cnt;

   modport master (
      output a_raw, b_raw, err_clr,
      input  a_out, b_out, chg, err, glitch_cnt
   );

   modport slave (
      input  a_raw, b_raw, err_clr,
      output a_out, b_out, chg, err, glitch_cnt
   );
endinterface

// File: rtl/quadrature_debounce.sv
// Synchronises and debounces one A/B encoder pin pair. It also flags same-edge A/B
// acceptance as a phase error and keeps a saturating count of rejected glitches.
module quadrature_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   quadrature_debounce_if.slave  bus
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

   function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] inc);
      logic [8:0] s;
      s = {1'b0, v} + {7'b0, inc};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   logic [SYNC_STAGES-1:0]  a_sync_q, a_sync_d;
   logic [SYNC_STAGES-1:0]  b_sync_q, b_sync_d;
   // Channel index 0 is A, index 1 is B.
   logic [1:0]              out_q, out_d;
   logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic                    chg_q, chg_d;
   logic                    err_q, err_d;
   logic [7:0]              glitch_cnt_q, glitch_cnt_d;

   logic [1:0]              x_sync;
   logic [1:0]              accept;
   logic [1:0]              glitch;

   always_comb begin
      a_sync_d = {a_sync_q[SYNC_STAGES-2:0], bus.a_raw};
      b_sync_d = {b_sync_q[SYNC_STAGES-2:0], bus.b_raw};
      x_sync   = {b_sync_q[SYNC_STAGES-1], a_sync_q[SYNC_STAGES-1]};

      out_d  = out_q;
      cnt_d  = cnt_q;
      accept = '0;
      glitch = '0;
      for (int ch = 0; ch < 2; ch++) begin
         if (x_sync[ch] == out_q[ch]) begin
            // A nonzero count here means a candidate level was abandoned.
            glitch[ch] = (cnt_q[ch] != '0);
            cnt_d[ch]  = '0;
         end else if (cnt_q[ch] + CNT_W'(1) == CNT_LAST) begin
            accept[ch] = 1'b1;
            out_d[ch]  = x_sync[ch];
            cnt_d[ch]  = '0;
         end else begin
            cnt_d[ch]  = cnt_q[ch] + CNT_W'(1);
         end
      end

      chg_d = |accept;
      // A new phase error outranks a simultaneous clear request.
      if (&accept) begin
         err_d = 1'b1;
      end else if (bus.err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end

      glitch_cnt_d = sat_add8(glitch_cnt_q, {1'b0, glitch[0]} + {1'b0, glitch[1]});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_sync_q     <= '0;
         b_sync_q     <= '0;
         out_q        <= '0;
         cnt_q        <= '0;
         chg_q        <= 1'b0;
         err_q        <= 1'b0;
         glitch_cnt_q <= '0;
      end else begin
         a_sync_q     <= a_sync_d;
         b_sync_q     <= b_sync_d;
         out_q        <= out_d;
         cnt_q        <= cnt_d;
         chg_q        <= chg_d;
         err_q        <= err_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign bus.a_out      = out_q[0];
   assign bus.b_out      = out_q[1];
   assign bus.chg        = chg_q;
   assign bus.err        = err_q;
   assign bus.glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_quadrature_debounce.sv
// Directed bench for quadrature_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_quadrature_debounce;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   quadrature_debounce_if qif ();

   quadrature_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (qif)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [1:0] gray [4];
   logic       pa, pb;

   initial begin
      qif.a_raw   = 1'b0;
      qif.b_raw   = 1'b0;
      qif.err_clr = 1'b0;

      // Reset held with raws toggling
      for (int i = 0; i < 8; i++) begin
         qif.a_raw = ~qif.a_raw;
         if (i % 3 == 0) qif.b_raw = ~qif.b_raw;
         tick(1);
      end
      chk("rst_a_out", 32'(qif.a_out), 0);
      chk("rst_b_out", 32'(qif.b_out), 0);
      chk("rst_chg", 32'(qif.chg), 0);
      chk("rst_err", 32'(qif.err), 0);
      chk("rst_glitch", 32'(qif.glitch_cnt), 0);
      qif.a_raw = 1'b0;
      qif.b_raw = 1'b0;
      reset_n   = 1'b1;
      tick(10);
      chk("post_rst_a", 32'(qif.a_out), 0);
      chk("post_rst_b", 32'(qif.b_out), 0);
      chk("post_rst_glitch", 32'(qif.glitch_cnt), 0);

      // Clean step on A
      qif.a_raw = 1'b1;
      tick(5);
      chk("step_e5_a", 32'(qif.a_out), 0);
      chk("step_e5_chg", 32'(qif.chg), 0);
      tick(1);
      chk("step_e6_a", 32'(qif.a_out), 1);
      chk("step_e6_chg", 32'(qif.chg), 1);
      tick(1);
      chk("step_e7_chg", 32'(qif.chg), 0);
      chk("step_err", 32'(qif.err), 0);
      chk("step_glitch", 32'(qif.glitch_cnt), 0);
      qif.a_raw = 1'b0;
      tick(10);
      chk("step_fall_a", 32'(qif.a_out), 0);
      chk("step_fall_glitch", 32'(qif.glitch_cnt), 0);

      // 3-cycle pulse is rejected
      qif.a_raw = 1'b1;
      tick(3);
      qif.a_raw = 1'b0;
      tick(10);
      chk("g3_a", 32'(qif.a_out), 0);
      chk("g3_glitch", 32'(qif.glitch_cnt), 1);

      // 4-cycle pulse is accepted and falls 4 cycles after it ends
      qif.a_raw = 1'b1;
      tick(4);
      qif.a_raw = 1'b0;
      tick(1);
      chk("g4_e5_a", 32'(qif.a_out), 0);
      tick(1);
      chk("g4_e6_a", 32'(qif.a_out), 1);
      chk("g4_e6_chg", 32'(qif.chg), 1);
      tick(3);
      chk("g4_e9_a", 32'(qif.a_out), 1);
      tick(1);
      chk("g4_e10_a", 32'(qif.a_out), 0);
      chk("g4_glitch", 32'(qif.glitch_cnt), 1);

      // Glitch counter saturation
      for (int i = 0; i < 300; i++) begin
         qif.b_raw = 1'b1;
         tick(1);
         qif.b_raw = 1'b0;
         tick(4);
         if (i == 9) chk("sat_mid", 32'(qif.glitch_cnt), 11);
      end
      tick(4);
      chk("sat_glitch", 32'(qif.glitch_cnt), 255);
      chk("sat_b_out", 32'(qif.b_out), 0);
      qif.err_clr = 1'b1;
      tick(1);
      qif.err_clr = 1'b0;
      tick(1);
      chk("sat_after_clr", 32'(qif.glitch_cnt), 255);

      // Phase error: simultaneous rise
      qif.a_raw = 1'b1;
      qif.b_raw = 1'b1;
      tick(5);
      chk("ph_e5_err", 32'(qif.err), 0);
      chk("ph_e5_a", 32'(qif.a_out), 0);
      tick(1);
      chk("ph_e6_a", 32'(qif.a_out), 1);
      chk("ph_e6_b", 32'(qif.b_out), 1);
      chk("ph_e6_err", 32'(qif.err), 1);
      chk("ph_e6_chg", 32'(qif.chg), 1);
      qif.err_clr = 1'b1;
      tick(1);
      qif.err_clr = 1'b0;
      chk("ph_clr_err", 32'(qif.err), 0);

      // Phase error with clear on the accept edge: set wins
      qif.a_raw = 1'b0;
      qif.b_raw = 1'b0;
      tick(5);
      qif.err_clr = 1'b1;
      tick(1);
      qif.err_clr = 1'b0;
      chk("ph2_a", 32'(qif.a_out), 0);
      chk("ph2_b", 32'(qif.b_out), 0);
      chk("ph2_err_set_wins", 32'(qif.err), 1);
      tick(1);
      chk("ph2_err_sticky", 32'(qif.err), 1);
      qif.err_clr = 1'b1;
      tick(1);
      qif.err_clr = 1'b0;
      chk("ph2_err_cleared", 32'(qif.err), 0);

      // Gray sweep, one change per 8 cycles
      gray[0] = 2'b10;
      gray[1] = 2'b11;
      gray[2] = 2'b01;
      gray[3] = 2'b00;
      pa = 1'b0;
      pb = 1'b0;
      for (int k = 0; k < 4; k++) begin
         qif.a_raw = gray[k][1];
         qif.b_raw = gray[k][0];
         tick(5);
         chk($sformatf("gray%0d_hold_a", k), 32'(qif.a_out), 32'(pa));
         chk($sformatf("gray%0d_hold_b", k), 32'(qif.b_out), 32'(pb));
         tick(1);
         chk($sformatf("gray%0d_a", k), 32'(qif.a_out), 32'(gray[k][1]));
         chk($sformatf("gray%0d_b", k), 32'(qif.b_out), 32'(gray[k][0]));
         chk($sformatf("gray%0d_chg", k), 32'(qif.chg), 1);
         tick(1);
         chk($sformatf("gray%0d_chg_off", k), 32'(qif.chg), 0);
         tick(1);
         pa = gray[k][1];
         pb = gray[k][0];
      end
      chk("gray_err", 32'(qif.err), 0);

      // Reset in the middle of a candidate change
      qif.b_raw = 1'b1;
      tick(8);
      chk("mid_b_before", 32'(qif.b_out), 1);
      qif.a_raw = 1'b1;
      tick(4);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_a", 32'(qif.a_out), 0);
      chk("mid_rst_b", 32'(qif.b_out), 0);
      chk("mid_rst_glitch", 32'(qif.glitch_cnt), 0);
      tick(2);
      reset_n = 1'b1;
      tick(5);
      chk("mid_e5_a", 32'(qif.a_out), 0);
      chk("mid_e5_b", 32'(qif.b_out), 0);
      tick(1);
      chk("mid_e6_a", 32'(qif.a_out), 1);
      chk("mid_e6_b", 32'(qif.b_out), 1);
      chk("mid_e6_err", 32'(qif.err), 1);
      chk("mid_e6_chg", 32'(qif.chg), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/quadrature_debounce.md
# quadrature_debounce

Input conditioner for one incremental encoder channel pair. It synchronises the raw A/B pins into the `clk` domain and rejects pulses shorter than a programmable number of cycles. It also flags illegal simultaneous A/B transitions and counts rejected glitches. It sits directly upstream of the quadrature decoder, which requires debounced, synchronous `a`/`b` inputs: `a_out`/`b_out` drive the decoder's `a`/`b` ports.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth per input, legal ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a new level must persist before it is accepted, legal ≥ 1. Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset. Assertion clears every flop immediately; release is sampled on `clk`.
- `a_raw` in 1: raw encoder A pin, asynchronous to `clk`.
- `b_raw` in 1: raw encoder B pin, asynchronous to `clk`.
- `err_clr` in 1: synchronous clear of `err`.
- `a_out` out 1: debounced A, registered.
- `b_out` out 1: debounced B, registered.
- `chg` out 1: one-cycle pulse, high in the cycle in which `a_out` or `b_out` holds a new value.
- `err` out 1: sticky phase error (A and B accepted on the same edge).
- `glitch_cnt` out 8: saturating count of rejected pulses.

## Operation
- **Synchroniser.** Each raw input passes through a `SYNC_STAGES` flop chain; the last stage is `x_sync`. There is no logic between stages.
- **Per-channel debounce.** Each channel holds its accepted level `x_out` and a counter `c`. On each edge:
  - `x_sync == x_out`: `c <= 0`.
  - `x_sync != x_out` and `c+1 < DEBOUNCE_CYCLES`: `c <= c+1`.
  - `x_sync != x_out` and `c+1 == DEBOUNCE_CYCLES`: `x_out <= x_sync`, `c <= 0`.
- **Glitch.** A glitch is `x_sync == x_out` while `c != 0` (a candidate level abandoned).
  - `glitch_cnt` increments by 1 per channel per glitch, so A and B glitching on the same edge adds 2.
  - It saturates at 255 and never wraps.
  - `err_clr` does not clear it; only reset does.
- **chg.** Registered; `chg <=` (A accept or B accept).
- **Phase error.** If A and B both accept on the same edge:
  - both outputs still update;
  - `err <= 1` and stays high until cleared.
  - `err_clr` with no new error clears `err` on the next edge.
  - Simultaneous new error and `err_clr`: the set wins and `err` stays 1.
- **DEBOUNCE_CYCLES = 1.** Output follows `x_sync` one edge later; glitches are never counted.
- **Reset.** All flops are 0: sync chains, `a_out`, `b_out`, `chg`, `err`, both counters, `glitch_cnt`.
  - With raws held high through reset release, both outputs rise together `SYNC_STAGES + DEBOUNCE_CYCLES` edges later.
  - This raises `err` and `chg`. This is expected; software clears `err` after start-up.
- **Reset mid-debounce.** The counters are lost and qualification restarts from 0 after release.

## Timing
- Raw edge held stable, captured at edge 1 → `x_sync` changes at edge `SYNC_STAGES` → `x_out` changes at edge `SYNC_STAGES + DEBOUNCE_CYCLES`. Default latency is 18 cycles.
- `chg` and `err` are high in the same cycle as the new `x_out`. `chg` is exactly 1 cycle wide.
- A pulse at `x_sync` lasting `DEBOUNCE_CYCLES - 1` cycles is rejected. One lasting `DEBOUNCE_CYCLES` cycles is accepted.
- `glitch_cnt` updates on the edge at which `x_sync` returns to `x_out`.
- Maximum accepted toggle rate per channel is one change per `DEBOUNCE_CYCLES` cycles.
- Downstream decode treats any A/B change faster than this as noise.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`.
- **Reset values.** Hold `reset_n=0` with raws toggling → all outputs 0. Release with raws at 0 → outputs remain 0 and `glitch_cnt=0`.
- **Clean step.** `a_raw` 0→1 just before edge 1 → `a_out=1` and `chg=1` at edge 6 only. `chg=0` at edge 7. `err=0`, `glitch_cnt=0`.
- **Glitch rejection.** `a_raw` pulse of 3 cycles → `a_out` stays 0 and `glitch_cnt=1`. A 4-cycle pulse → `a_out` rises, then falls 4 cycles after the pulse ends.
- **Glitch saturation.** 300 short B pulses → `glitch_cnt=255`. `err_clr` → still 255.
- **Phase error.** `a_raw` and `b_raw` rise on the same cycle → both outputs 1 on the same edge with `err=1`. Pulse `err_clr` → `err=0` next edge. Repeat with `err_clr` asserted on the accept edge → `err=1`.
- **Quadrature sweep and reset mid-operation.** Gray sequence 00→10→11→01→00 at 8-cycle spacing → outputs reproduce it, 6-cycle delay, `err=0`. Assert `reset_n` 2 cycles into a candidate change → outputs 0 immediately; no acceptance until a full 4-cycle qualification after release.
